dly_ctrl: RTL and testbench
===========================

// Module: dly_ctrl
// PURPOSE
//  Runtime-programmable delay line for a DW-bit signal: sig_dly follows sig delayed by dly_cur clocks.
//  Owns the tapped shift register and sequences glitch-free delay changes over a valid/ready
//  config port, so the delay can be retuned without output glitches.
// PARAMETERS
//  MAX_DLY  16  deepest supported delay in clocks (>=1)
//  DW       1   width of sig / sig_dly
//  RST_DLY  1   delay in effect out of reset (0..MAX_DLY)
//  CW       $clog2(MAX_DLY+1)  derived; width of delay fields, not overridden
// PORTS
//  clk        in   1   sole clock, all state on posedge
//  rst_n      in   1   asynchronous active-low reset
//  sig        in   DW  signal to delay
//  sig_dly    out  DW  delayed signal
//  cfg_valid  in   1   new delay request present
//  cfg_dly    in   CW  requested delay in clocks
//  cfg_ready  out  1   request accepted on a clk edge where cfg_valid&&cfg_ready
//  dly_cur    out  CW  delay currently applied to sig_dly
//  busy       out  1   HOLD in progress
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk release): line stages=0, hold_q=0, dly_cur=RST_DLY, state=RUN,
//    cfg_ready=1, busy=0; sig_dly=0 when RST_DLY>0, =sig when RST_DLY==0.
//  - Line: stage[0]<=sig, stage[i]<=stage[i-1] every clock in every state; it never stalls.
//  - RUN: sig_dly = sig if dly_cur==0 (combinational bypass), else stage[dly_cur-1].
//  - cfg_ready = (state==RUN). busy = (state==HOLD). Request honoured only when cfg_ready=1.
//  - Accept: req = min(cfg_dly, MAX_DLY) (clamp, no error flag).
//    * req <= dly_cur: dly_cur<=req at the accept edge; stay RUN; samples dropped on a decrease
//      (inherent); req==dly_cur is a no-op accept.
//    * req > dly_cur: hold_q<=current sig_dly, cnt<=req-dly_cur, dly_cur<=req, go HOLD.
//  - HOLD: sig_dly=hold_q; cnt decrements each clock; at cnt==1 the edge returns to RUN.
//    busy is high exactly req-old cycles, then sig_dly resumes from the next undelivered sample:
//    no skip and no repeat beyond the hold itself.
//  - cfg_valid held during HOLD: stalls, accepted on the first RUN cycle. cfg_dly is sampled only
//    at the accept edge.
//  - rst_n low mid-HOLD: immediate reset values; the pending change is abandoned.
//  - dly_cur is registered and updates at the accept edge, so it reads the new target during HOLD.
// CONFIGURATION
//  DLY_CTRL_STATS_EN defined: extra output cfg_cnt [7:0], reset 0, +1 on every accept
//    (no-ops included), wraps 255->0.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  dly_pkg: typedef enum logic {DLY_RUN, DLY_HOLD} dly_state_e; function dly_clamp(req, max).
//  Sub-module dly_line #(MAX_DLY,DW): stage register plus tap mux (tap 0 = bypass).
//    dly_ctrl keeps the FSM, cnt and hold_q.
// TESTING (MAX_DLY=16, DW=1, RST_DLY=1; sig driven 1 time unit after posedge)
//  1. Reset release, sig 0->1 after edge 3 -> sig_dly rises 1 clk later; dly_cur=1, cfg_ready=1, busy=0.
//  2. cfg_dly=4 from 1 -> busy high exactly 3 clks, sig_dly==hold_q throughout; afterwards
//     sig_dly==sig delayed 4, with no sample skipped (check against a reference queue).
//  3. cfg_dly=2 from 4 -> accepted, busy stays 0, dly_cur=2 next cycle; sig_dly==sig delayed 2.
//  4. cfg_dly=20 from 2 -> clamped, dly_cur=16, busy high 14 clks.
//  5. cfg_valid held high through a HOLD with cfg_dly=3 -> cfg_ready=0 while busy; accepted on the
//     first RUN edge; cfg_cnt (STATS_EN) increments once per accept.
//  6. rst_n low 2 clks after a 1->8 accept -> async: sig_dly=0, dly_cur=1, busy=0, cfg_ready=1.

Source files
------------

// File: rtl/dly_pkg.sv
// Shared types and helpers for the programmable delay line controller.
package dly_pkg;

  typedef enum logic {
    DLY_RUN  = 1'b0,
    DLY_HOLD = 1'b1
  } dly_state_e;

  // Saturate a requested delay at the deepest tap the line provides.
  function automatic int unsigned dly_clamp(input int unsigned req, input int unsigned max_dly);
    return (req > max_dly) ? max_dly : req;
  endfunction

endpackage

// File: rtl/dly_line.sv
// Free-running tapped shift register; tap 0 bypasses the line and returns sig_i unregistered.
module dly_line #(
  parameter int unsigned MAX_DLY = 16,
  parameter int unsigned DW      = 1,
  localparam int unsigned CW     = $clog2(MAX_DLY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] sig_i,
  input  logic [CW-1:0] tap_i,
  output logic [DW-1:0] dly_o
);

  logic [DW-1:0] stage_q [MAX_DLY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_DLY); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= sig_i;
      for (int i = 1; i < int'(MAX_DLY); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // stage_q[k-1] holds sig_i from k clocks ago.
  always_comb begin
    dly_o = sig_i;
    for (int i = 1; i <= int'(MAX_DLY); i++) begin
      if (tap_i == CW'(i)) begin
        dly_o = stage_q[i-1];
      end
    end
  end

endmodule

// File: rtl/dly_ctrl.sv
// Runtime-retunable delay line with glitch-free delay increases via a HOLD phase.
// Optional DLY_CTRL_STATS_EN adds cfg_cnt, a wrapping count of accepted requests.
module dly_ctrl
  import dly_pkg::*;
#(
  parameter int unsigned MAX_DLY = 16,
  parameter int unsigned DW      = 1,
  parameter int unsigned RST_DLY = 1,
  localparam int unsigned CW     = $clog2(MAX_DLY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] sig,
  output logic [DW-1:0] sig_dly,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_dly,
  output logic          cfg_ready,
  output logic [CW-1:0] dly_cur,
  output logic          busy
`ifdef DLY_CTRL_STATS_EN
  ,
  output logic [7:0]    cfg_cnt
`endif
);

  dly_state_e    state_q;
  logic [CW-1:0] dly_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] hold_q;
  logic          ready_q;
  logic          busy_q;
  logic [CW-1:0] req_d;
  logic [DW-1:0] tap_dly;
  logic          accept;

  dly_line #(
    .MAX_DLY (MAX_DLY),
    .DW      (DW)
  ) u_line (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_i (sig),
    .tap_i (dly_q),
    .dly_o (tap_dly)
  );

  assign req_d  = CW'(dly_clamp(32'(cfg_dly), MAX_DLY));
  assign accept = cfg_valid && ready_q;

  // An increase freezes the output on the last delivered sample until the line
  // has filled to the new depth, so no sample is skipped or repeated afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DLY_RUN;
      dly_q   <= CW'(RST_DLY);
      cnt_q   <= '0;
      hold_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        DLY_RUN: begin
          if (accept) begin
            dly_q <= req_d;
            if (req_d > dly_q) begin
              hold_q  <= tap_dly;
              cnt_q   <= req_d - dly_q;
              state_q <= DLY_HOLD;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        DLY_HOLD: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DLY_RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= DLY_RUN;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sig_dly   = busy_q ? hold_q : tap_dly;
  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign dly_cur   = dly_q;

`ifdef DLY_CTRL_STATS_EN
  logic [7:0] cfg_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_cnt_q <= '0;
    end else if (accept) begin
      cfg_cnt_q <= cfg_cnt_q + 8'd1;
    end
  end

  assign cfg_cnt = cfg_cnt_q;
`endif

endmodule

// File: tb/tb_dly_ctrl.sv
// Scoreboard bench for dly_ctrl: the driver queues per-cycle expectations, a negedge monitor checks them.
module tb_dly_ctrl;

  localparam int MAX_DLY = 16;
  localparam int DW      = 1;
  localparam int RST_DLY = 1;
  localparam int CW      = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sig = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [CW-1:0] cfg_dly = '0;
  logic          sig_dly;
  logic          cfg_ready;
  logic          busy;
  logic [CW-1:0] dly_cur;
`ifdef DLY_CTRL_STATS_EN
  logic [7:0]    cfg_cnt;
`endif

  dly_ctrl #(
    .MAX_DLY (MAX_DLY),
    .DW      (DW),
    .RST_DLY (RST_DLY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig       (sig),
    .sig_dly   (sig_dly),
    .cfg_valid (cfg_valid),
    .cfg_dly   (cfg_dly),
    .cfg_ready (cfg_ready),
    .dly_cur   (dly_cur),
    .busy      (busy)
`ifdef DLY_CTRL_STATS_EN
    ,
    .cfg_cnt   (cfg_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          s;
    logic          bsy;
    logic          rdy;
    logic [CW-1:0] dly;
    logic [7:0]    cnt;
  } exp_t;

  // Request with hand-computed hold length and resulting delay.
  typedef struct {
    logic [CW-1:0] dly;
    int            h;
    int            d;
  } req_t;

  exp_t expq[$];
  req_t reqq[$];
  logic hist[$];

  int errors = 0;
  int checks = 0;

  int         hold_left = 0;
  int         exp_dly_m = RST_DLY;
  logic       hold_val  = 1'b0;
  logic       last_sig  = 1'b0;
  logic [7:0] cnt_m     = '0;
  bit         acc_pend  = 1'b0;
  int         acc_h     = 0;
  int         acc_d     = 0;
  logic [31:0] pat      = 32'hB4E1_9C36;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("sig_dly", 32'(sig_dly), 32'(e.s));
      chk("busy", 32'(busy), 32'(e.bsy));
      chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
      chk("dly_cur", 32'(dly_cur), 32'(e.dly));
`ifdef DLY_CTRL_STATS_EN
      chk("cfg_cnt", 32'(cfg_cnt), 32'(e.cnt));
`endif
    end
  end

  task automatic push_req(input int dly, input int h, input int d);
    req_t r;
    r.dly = CW'(dly);
    r.h   = h;
    r.d   = d;
    reqq.push_back(r);
  endtask

  task automatic cycle(input logic s);
    exp_t e;
    int   idx;
    @(posedge clk);
    #1;
    if (hold_left > 0) hold_left--;
    if (acc_pend) begin
      hold_val  = last_sig;
      hold_left = acc_h;
      exp_dly_m = acc_d;
      cnt_m     = cnt_m + 8'd1;
      acc_pend  = 1'b0;
    end
    sig = s;
    hist.push_back(s);
    e.rdy = (hold_left == 0);
    e.bsy = !e.rdy;
    if (e.bsy) begin
      e.s = hold_val;
    end else begin
      idx = hist.size() - 1 - exp_dly_m;
      e.s = (idx < 0) ? 1'b0 : hist[idx];
    end
    e.dly = CW'(exp_dly_m);
    e.cnt = cnt_m;
    if (reqq.size() > 0) begin
      cfg_valid = 1'b1;
      cfg_dly   = reqq[0].dly;
      if (e.rdy) begin
        acc_pend = 1'b1;
        acc_h    = reqq[0].h;
        acc_d    = reqq[0].d;
        void'(reqq.pop_front());
      end
    end else begin
      cfg_valid = 1'b0;
      cfg_dly   = CW'(17);
    end
    last_sig = e.s;
    expq.push_back(e);
  endtask

  task automatic run(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      cycle(pat[(base + i) % 32]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sig_dly"}, 32'(sig_dly), 32'd0);
    chk({tag, "_dly_cur"}, 32'(dly_cur), 32'(RST_DLY));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
`ifdef DLY_CTRL_STATS_EN
    chk({tag, "_cfg_cnt"}, 32'(cfg_cnt), 32'd0);
`endif
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    sig       = 1'b0;
    cfg_valid = 1'b0;
    hist.delete();
    hist.push_back(1'b0);
    reqq.delete();
    hold_left = 0;
    exp_dly_m = RST_DLY;
    cnt_m     = '0;
    acc_pend  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_init");
    release_rst();

    // 1: step response at reset delay
    cycle(1'b0); cycle(1'b0); cycle(1'b0);
    repeat (4) cycle(1'b1);
    cycle(1'b0); cycle(1'b1); cycle(1'b0);

    // 2: increase 1 -> 4
    push_req(4, 3, 4);
    run(14, 0);

    // 3: decrease 4 -> 2
    push_req(2, 0, 2);
    run(10, 5);

    // 4: clamped request 20 -> 16
    push_req(20, 14, 16);
    run(36, 9);

    // 5: decrease to 1, then a request held through the HOLD of 1 -> 5
    push_req(1, 0, 1);
    run(4, 13);
    push_req(5, 4, 5);
    push_req(3, 0, 3);
    run(12, 17);
    push_req(3, 0, 3);
    run(5, 21);

    // zero delay bypass, then increase from zero
    push_req(0, 0, 0);
    run(6, 2);
    push_req(2, 2, 2);
    run(8, 11);
    push_req(1, 0, 1);
    run(4, 27);

    // 6: reset two clocks into a 1 -> 8 hold
    push_req(8, 7, 8);
    cycle(1'b1); cycle(1'b0); cycle(1'b1);
    cycle(1'b1);
    @(posedge clk);
    #3;
    sig       = 1'b1;
    cfg_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_reset_state("rst_async");
    repeat (2) @(posedge clk);
    release_rst();
    run(12, 3);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
